// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution output stage.
package conv_pkg;

  localparam int CONV_DATA_W = 25;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/relu_fifo.sv
// Small synchronous FIFO holding {relu data, address} entries for the output stage.
module relu_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count != FULL);
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  // Empty FIFO presents zero so the head never shows stale or uninitialised data.
  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/conv_out_sched.sv
// Output-stage scheduler: ReLU, address tagging and buffering of one feature map per start.
module conv_out_sched
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int OUT_W  = 6,
  parameter int OUT_H  = 6,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_conv,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [ADDR_W-1:0]        out_addr,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] ROW_LEN  = ADDR_W'(OUT_W);
  localparam logic signed [DATA_W-1:0] ZERO = '0;

  sched_state_t             state;
  logic [ADDR_W-1:0]        col;
  logic [ADDR_W-1:0]        row;
  logic [CNT_W-1:0]         count;
  logic                     push;
  logic                     pop;
  logic                     start_ok;
  logic                     last_pos;
  logic                     flush;
  logic [DATA_W-1:0]        relu_data;
  logic [ADDR_W-1:0]        addr;
  logic [DATA_W+ADDR_W-1:0] head;

  assign in_ready  = (state == RUN) && (count < FULL);
  assign out_valid = (count != '0);
  assign busy      = (state != IDLE);

  assign push     = in_valid && in_ready && !abort;
  assign pop      = out_valid && out_ready;
  assign start_ok = (state == IDLE) && start_conv && !abort;
  assign flush    = abort || start_ok;
  assign last_pos = (col == COL_LAST) && (row == ROW_LAST);

  assign relu_data = (in_data < ZERO) ? '0 : in_data;
  assign addr      = row * ROW_LEN + col;

  relu_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({relu_data, addr}),
    .rdata (head),
    .count (count)
  );

  assign out_data = head[DATA_W+ADDR_W-1:ADDR_W];
  assign out_addr = head[ADDR_W-1:0];

  // Abort overrides every state; an accepted start wins over a same-cycle err set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok)                         err <= 1'b0;
      else if (in_valid && (state != RUN))  err <= 1'b1;

      if (abort) begin
        state <= IDLE;
        col   <= '0;
        row   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_conv) begin
              state <= RUN;
              col   <= '0;
              row   <= '0;
            end
          end
          RUN: begin
            if (push) begin
              if (last_pos) begin
                state <= DRAIN;
                col   <= '0;
                row   <= '0;
              end else if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          DRAIN: begin
            if ((count == '0) || ((count == ONE) && pop)) state <= DONE;
          end
          DONE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_out_sched.sv
// Scoreboard bench for conv_out_sched on a 3x2 map with a 4-entry FIFO.
module tb_conv_out_sched;

  localparam int DATA_W = 25;
  localparam int OUT_W  = 3;
  localparam int OUT_H  = 2;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;
  localparam int NPOS   = OUT_W * OUT_H;
  localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start_conv;
  logic                     abort;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [ADDR_W-1:0]        out_addr;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic                     err;

  logic [DATA_W-1:0] exp_data[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int total = 0;
  int bad = 0;
  int cycle = 0;
  int done_count = 0;
  int pop_count = 0;
  int next_addr = 0;
  int start_cycle = 0;
  int done_before = 0;
  int pops_before = 0;

  conv_out_sched #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .OUT_H  (OUT_H),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_conv (start_conv),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic logic [DATA_W-1:0] relu_model(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? '0 : v;
  endfunction

  // Output monitor: every accepted head is checked against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (done) done_count++;
    if (out_valid && out_ready) begin
      pop_count++;
      if (exp_data.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        checkOutput("out_data", 32'(out_data), 32'(exp_data.pop_front()));
        checkOutput("out_addr", 32'(out_addr), 32'(exp_addr.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input logic signed [DATA_W-1:0] v);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 0, 1);
    end else begin
      exp_data.push_back(relu_model(v));
      exp_addr.push_back(ADDR_W'(next_addr));
      next_addr = (next_addr + 1) % NPOS;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic start_map();
    start_conv = 1'b1;
    next_addr  = 0;
    @(posedge clk);
    #1;
    start_cycle = cycle;
    start_conv  = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < max_cycles);
    checkOutput("done_seen", 32'(done), 1);
  endtask

  task automatic clear_sb();
    exp_data.delete();
    exp_addr.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start_conv = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_out_addr", 32'(out_addr), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] full map with boundary values");
    out_ready = 1'b1;
    done_before = done_count;
    start_map();
    @(negedge clk);
    checkOutput("start_busy", 32'(busy), 1);
    checkOutput("start_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    start_cycle = start_cycle + 1;
    applyStimulus(25'sd5);
    applyStimulus(-25'sd3);
    applyStimulus(25'sd0);
    applyStimulus(-25'sd1);
    applyStimulus(MINV);
    applyStimulus(MAXV);
    wait_done(40);
    checkOutput("done_latency", 32'(cycle - start_cycle), 32'(NPOS + 2));
    @(negedge clk);
    checkOutput("done_width", 32'(done), 0);
    checkOutput("done_once", 32'(done_count - done_before), 1);
    checkOutput("sb_empty_map1", 32'(exp_data.size()), 0);
    checkOutput("err_map1", 32'(err), 0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    pops_before = pop_count;
    start_map();
    applyStimulus(25'sd7);
    applyStimulus(-25'sd8);
    applyStimulus(25'sd100);
    applyStimulus(25'sd42);
    in_valid  = 1'b1;
    in_data   = 25'sd9;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("full_in_ready", 32'(in_ready), 0);
    checkOutput("full_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    checkOutput("after_pop_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    applyStimulus(25'sd9);
    out_ready = 1'b1;
    applyStimulus(25'sd1234);
    wait_done(40);
    @(negedge clk);
    checkOutput("bp_all_popped", 32'(pop_count - pops_before), 32'(NPOS));
    checkOutput("sb_empty_bp", 32'(exp_data.size()), 0);

    $display("[TB] abort mid-map");
    out_ready = 1'b0;
    start_map();
    applyStimulus(25'sd1);
    applyStimulus(25'sd2);
    applyStimulus(25'sd3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    abort = 1'b1;
    done_before = done_count;
    @(posedge clk); #1;
    abort = 1'b0;
    clear_sb();
    @(negedge clk);
    checkOutput("abort_out_valid", 32'(out_valid), 0);
    checkOutput("abort_in_ready", 32'(in_ready), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_count - done_before), 0);

    $display("[TB] err in idle and ignored start");
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 25'sd77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("err_set", 32'(err), 1);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", 32'(err), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    done_before = done_count;
    start_map();
    @(negedge clk);
    checkOutput("err_cleared", 32'(err), 0);
    @(posedge clk); #1;
    applyStimulus(25'sd11);
    start_conv = 1'b1;
    applyStimulus(-25'sd5);
    start_conv = 1'b0;
    applyStimulus(25'sd13);
    applyStimulus(25'sd14);
    applyStimulus(-25'sd15);
    applyStimulus(25'sd16);
    wait_done(40);
    @(negedge clk);
    checkOutput("restart_done_once", 32'(done_count - done_before), 1);
    checkOutput("sb_empty_restart", 32'(exp_data.size()), 0);
    checkOutput("run_no_err", 32'(err), 0);

    $display("[TB] reset during drain");
    start_map();
    for (int i = 0; i < NPOS - 1; i++) applyStimulus(25'(i * 3 - 4));
    out_ready = 1'b0;
    applyStimulus(25'sd500);
    @(negedge clk);
    checkOutput("drain_busy", 32'(busy), 1);
    checkOutput("drain_in_ready", 32'(in_ready), 0);
    checkOutput("drain_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_sb();
    @(negedge clk);
    checkOutput("rst2_in_ready", 32'(in_ready), 0);
    checkOutput("rst2_out_valid", 32'(out_valid), 0);
    checkOutput("rst2_out_data", 32'(out_data), 0);
    checkOutput("rst2_out_addr", 32'(out_addr), 0);
    checkOutput("rst2_busy", 32'(busy), 0);
    checkOutput("rst2_done", 32'(done), 0);
    checkOutput("rst2_err", 32'(err), 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_out_sched.md
# conv_out_sched

Output-stage scheduler for the convolution kernel. It accepts 25-bit signed accumulator results from the MAC array and applies ReLU to each one. It tags each result with its feature-map address (row-major) and buffers it in a small FIFO. It then hands results to the output memory over a valid/ready handshake. It sequences one feature map per `start_conv` pulse and reports completion with a one-cycle `done`.

## Interface
- `DATA_W`, 25, accumulator / result width (signed).
- `OUT_W`, 6, feature-map columns (≥1).
- `OUT_H`, 6, feature-map rows (≥1).
- `DEPTH`, 4, FIFO entries (power of two, ≥2).
- `ADDR_W`, 6, output address width; must satisfy 2^ADDR_W ≥ OUT_W*OUT_H.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_conv`  in  1  pulse; starts a feature map; honoured only in IDLE.
- `abort`  in  1  pulse; flushes and returns to IDLE from any state.
- `in_valid`  in  1  accumulator result valid.
- `in_data`  in  DATA_W  signed accumulator result.
- `in_ready`  out  1  scheduler accepts `in_data` this cycle.
- `out_valid`  out  1  FIFO head valid.
- `out_data`  out  DATA_W  ReLU result (always ≥0).
- `out_addr`  out  ADDR_W  row*OUT_W+col of `out_data`.
- `out_ready`  in  1  output memory accepts the head.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the last result of a map has been popped.
- `err`  out  1  sticky; set by `in_valid` while not in RUN; cleared by `start_conv` accepted or `rst`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on `start_conv`. Column counter, row counter, FIFO pointers and `err` clear in the same edge.
- In RUN, a push happens when `in_valid && in_ready`.
  - Stored data is `in_data < 0 ? 0 : in_data`.
  - Stored address is `row*OUT_W+col`.
- Position update on each push:
  - `col` increments.
  - At `col == OUT_W-1`, `col` wraps to 0 and `row` increments.
- The push of position OUT_W*OUT_H-1 moves RUN -> DRAIN.
- DRAIN -> DONE when the FIFO is empty, including when it becomes empty in the same cycle.
- DONE asserts `done` for exactly one cycle and then goes to IDLE.
- `in_ready = (state==RUN) && (count < DEPTH)`. There is no pass-through when full, even if a pop occurs in the same cycle.
- `out_valid = (count != 0)`. A pop happens when `out_valid && out_ready`.
- Simultaneous push and pop leave `count` unchanged. Both pointers advance modulo DEPTH.
- `abort` has priority over everything except `rst`:
  - next state is IDLE;
  - FIFO is emptied;
  - counters clear;
  - `done` is not asserted.
- `start_conv` in RUN, DRAIN or DONE is ignored, and the map in progress continues.
- `in_valid` outside RUN sets `err` and the data is dropped. In RUN, a stalled `in_valid` (full FIFO) is not an error.
- Arithmetic:
  - ReLU compares on the full signed DATA_W.
  - Address arithmetic is unsigned, ADDR_W bits, and never wraps for legal parameters.

## Timing
- Reset values: state IDLE; `in_ready` 0, `out_valid` 0, `out_data` 0, `out_addr` 0, `busy` 0, `done` 0, `err` 0; `count` 0.
- Latency: a result pushed at edge N appears on `out_*` after edge N if the FIFO was empty. There is no combinational in→out path.
- `in_ready` and `out_valid` depend only on registered state. `out_ready` has no combinational effect on `in_ready`.
- `start_conv` at edge N gives `busy=1` and `in_ready=1` from N.
- With `out_ready` held at 1 and `in_valid` held at 1, throughput is one result per cycle. `done` occurs OUT_W*OUT_H+2 cycles after `start_conv`.
- `rst` or `abort` mid-map: the next cycle shows `out_valid=0` and `in_ready=0`.

## Structure
- Shared package `conv_pkg`:
  - state enum `sched_state_t` {IDLE, RUN, DRAIN, DONE};
  - constant `CONV_DATA_W = 25`.
- Sub-module `relu_fifo`:
  - DEPTH×(DATA_W+ADDR_W) synchronous FIFO with `count`, `push`, `pop`, and a `flush` input;
  - holds no FSM logic.
- Top: FSM, position counters, ReLU, and `err`/`done` logic.

## Test plan
- Full map, OUT_W=OUT_H=2, `out_ready`=1.
  - Stimulus: inputs 5, −3, 0, −1.
  - Required: outputs (5,0), (0,1), (0,2), (0,3).
  - Required: `done` exactly one cycle, 6 cycles after `start_conv`.
- Backpressure, DEPTH=4, `out_ready`=0.
  - Stimulus: 6 inputs offered.
  - Required: `in_ready` drops after 4 pushes.
  - Required: after `out_ready`=1, all values arrive in order with addresses 0..5 and none are lost.
- Simultaneous push/pop at `count`=4: `in_ready`=0 that cycle, and `count` becomes 3 afterwards.
- Abort mid-map after 3 pushes with 2 still buffered:
  - `out_valid`=0 next cycle and no `done`;
  - the next `start_conv` restarts at address 0.
- Ignored start and error:
  - `start_conv` pulsed during RUN: addresses continue uninterrupted.
  - `in_valid`=1 in IDLE sets `err`, which stays set until the next accepted `start_conv`.
- Boundary: input −2^24 → 0; input 2^24−1 → 2^24−1; `rst` asserted during DRAIN → all outputs return to reset values the next cycle.
